// File: rtl/writeback.sv
// Writeback stage: issues data-memory loads/stores over a req/ack handshake,
// aligns and extends load data, and writes results to the register file.
//
// Handshake: a request (dmem_rreq / dmem_wreq) and its address/data are raised
// together and held unchanged until the matching response (dmem_rvalid /
// dmem_wack) is seen on a rising edge. The request drops on that same edge.
// A response with no request outstanding is ignored. If no response arrives
// within TIMEOUT cycles, the request is withdrawn and bus_err pulses.
module writeback #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_result,
  input  logic        wb_memwr,
  input  logic        wb_alu2reg,
  input  logic        wb_mem2reg,
  input  logic [4:0]  wb_dst_sel,
  input  logic [1:0]  wb_raddr,
  input  logic [2:0]  wb_aluop,
  input  logic [31:0] wb_waddr,
  input  logic [3:0]  wb_wstrb,
  input  logic [31:0] wb_wdata,
  output logic        wb_stall,
  output logic        dmem_rreq,
  output logic [31:0] dmem_raddr,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_wreq,
  output logic [31:0] dmem_waddr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_wack,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic [4:0]       ld_dst;
  logic [2:0]       ld_op;
  logic [1:0]       ld_lane;
  logic             ld_misaligned;
  logic             expire;

  // Select and extend the addressed byte/half; funct3 3, 6 and 7 behave as LW.
  function automatic logic [31:0] extract(input logic [2:0] op,
                                          input logic [1:0] lane,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Halfword loads need an even lane, word loads (incl. aliases) lane 0.
  assign ld_misaligned = ((wb_aluop[1:0] == 2'b01) && wb_raddr[0]) ||
                         (wb_aluop[1] && (wb_raddr != 2'b00));

  assign expire    = TO_EN && (to_cnt == TO_LAST);
  assign wb_stall  = (state != IDLE);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wb_mem2reg) begin
          if (!ld_misaligned) state_nxt = RD;
        end else if (wb_memwr) begin
          state_nxt = WR;
        end
      end
      RD:      if (dmem_rvalid || expire) state_nxt = IDLE;
      WR:      if (dmem_wack || expire)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout counter: zero while idle, so it starts from 0 on entry to RD/WR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              to_cnt <= '0;
    else if (state == IDLE) to_cnt <= '0;
    else                    to_cnt <= to_cnt + CNT_W'(1);
  end

  // Registered memory-interface, register-file and error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_rreq    <= 1'b0;
      dmem_raddr   <= '0;
      dmem_wreq    <= 1'b0;
      dmem_waddr   <= '0;
      dmem_wstrb   <= '0;
      dmem_wdata   <= '0;
      reg_we       <= 1'b0;
      reg_waddr    <= '0;
      reg_wdata    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      ld_dst       <= '0;
      ld_op        <= '0;
      ld_lane      <= '0;
    end else begin
      reg_we       <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_mem2reg) begin
            if (ld_misaligned) begin
              misalign_err <= 1'b1;
            end else begin
              ld_dst     <= wb_dst_sel;
              ld_op      <= wb_aluop;
              ld_lane    <= wb_raddr;
              dmem_raddr <= {wb_result[31:2], 2'b00};
              dmem_rreq  <= 1'b1;
            end
          end else if (wb_memwr) begin
            dmem_waddr <= wb_waddr;
            dmem_wstrb <= wb_wstrb;
            dmem_wdata <= wb_wdata;
            dmem_wreq  <= 1'b1;
          end else if (wb_alu2reg) begin
            reg_we    <= (wb_dst_sel != 5'd0);
            reg_waddr <= wb_dst_sel;
            reg_wdata <= wb_result;
          end
        end
        RD: begin
          if (dmem_rvalid) begin
            dmem_rreq <= 1'b0;
            reg_we    <= (ld_dst != 5'd0);
            reg_waddr <= ld_dst;
            reg_wdata <= extract(ld_op, ld_lane, dmem_rdata);
          end else if (expire) begin
            dmem_rreq <= 1'b0;
            bus_err   <= 1'b1;
          end
        end
        WR: begin
          if (dmem_wack) begin
            dmem_wreq <= 1'b0;
          end else if (expire) begin
            dmem_wreq <= 1'b0;
            bus_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback (built with a 4-cycle timeout).
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_result;
  logic        wb_memwr, wb_alu2reg, wb_mem2reg;
  logic [4:0]  wb_dst_sel;
  logic [1:0]  wb_raddr;
  logic [2:0]  wb_aluop;
  logic [31:0] wb_waddr;
  logic [3:0]  wb_wstrb;
  logic [31:0] wb_wdata;
  logic        wb_stall;
  logic        dmem_rreq;
  logic [31:0] dmem_raddr;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_wreq;
  logic [31:0] dmem_waddr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_wack;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        misalign_err, bus_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected register writes {waddr, wdata} and error events {bus, misalign}.
  logic [36:0] exp_q[$];
  logic [1:0]  exp_err_q[$];

  writeback #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .wb_result(wb_result), .wb_memwr(wb_memwr), .wb_alu2reg(wb_alu2reg),
    .wb_mem2reg(wb_mem2reg), .wb_dst_sel(wb_dst_sel), .wb_raddr(wb_raddr),
    .wb_aluop(wb_aluop), .wb_waddr(wb_waddr), .wb_wstrb(wb_wstrb),
    .wb_wdata(wb_wdata), .wb_stall(wb_stall),
    .dmem_rreq(dmem_rreq), .dmem_raddr(dmem_raddr), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_wreq(dmem_wreq), .dmem_waddr(dmem_waddr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_wack(dmem_wack),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .misalign_err(misalign_err), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] lane,
                                             input logic [31:0] w);
    logic [31:0] v;
    int sh_b, sh_h;
    sh_b = 8 * int'(lane);
    sh_h = 16 * (int'(lane) / 2);
    if (op == 3'd0 || op == 3'd4) begin
      v = (w >> sh_b) & 32'hFF;
      if (op == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (op == 3'd1 || op == 3'd5) begin
      v = (w >> sh_h) & 32'hFFFF;
      if (op == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Compare process: every register write / error pulse must match the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_we) begin
        if (exp_q.size() == 0) chk("unexpected_reg_we", {32'd0, reg_we}, 37'd0);
        else chk("reg_write", {reg_waddr, reg_wdata}, exp_q.pop_front());
      end
      if (misalign_err || bus_err) begin
        if (exp_err_q.size() == 0) chk("unexpected_err", {35'd0, bus_err, misalign_err}, 37'd0);
        else chk("err_event", {35'd0, bus_err, misalign_err}, {35'd0, exp_err_q.pop_front()});
      end
    end
  end

  task automatic clear_inputs();
    wb_result = '0; wb_memwr = 0; wb_alu2reg = 0; wb_mem2reg = 0;
    wb_dst_sel = '0; wb_raddr = '0; wb_aluop = '0;
    wb_waddr = '0; wb_wstrb = '0; wb_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_alu(input logic [4:0] dst, input logic [31:0] res);
    if (dst != 0) exp_q.push_back({dst, res});
    wb_alu2reg = 1; wb_dst_sel = dst; wb_result = res;
    step(); clear_inputs();
    chk("alu_we", {36'd0, reg_we}, {36'd0, (dst != 0)});
    if (dst != 0) chk("alu_data", {reg_waddr, reg_wdata}, {dst, res});
    step();
    chk("alu_we_pulse", {36'd0, reg_we}, 37'd0);
  endtask

  task automatic issue_load(input logic [31:0] addr, input logic [2:0] op, input logic [4:0] dst);
    wb_mem2reg = 1; wb_result = addr; wb_raddr = addr[1:0]; wb_aluop = op; wb_dst_sel = dst;
    step(); clear_inputs();
  endtask

  // Load answered after `waits` idle RD cycles; exp_lit is hand-computed.
  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] op,
                         input logic [4:0] dst, input logic [31:0] rdata, input int waits,
                         input logic [31:0] exp_lit);
    int rq_cnt = 0;
    int st_cnt = 0;
    chk({name, "_model"}, {5'd0, model_load(op, addr[1:0], rdata)}, {5'd0, exp_lit});
    if (dst != 0) exp_q.push_back({dst, model_load(op, addr[1:0], rdata)});
    issue_load(addr, op, dst);
    chk({name, "_raddr"}, {5'd0, dmem_raddr}, {5'd0, addr[31:2], 2'b00});
    for (int i = 0; i < waits; i++) begin
      rq_cnt += int'(dmem_rreq); st_cnt += int'(wb_stall);
      step();
    end
    rq_cnt += int'(dmem_rreq); st_cnt += int'(wb_stall);
    dmem_rvalid = 1; dmem_rdata = rdata;
    step();
    dmem_rvalid = 0; dmem_rdata = '0;
    chk({name, "_rreq_cycles"}, 37'(rq_cnt), 37'(waits + 1));
    chk({name, "_stall_cycles"}, 37'(st_cnt), 37'(waits + 1));
    chk({name, "_done"}, {34'd0, dmem_rreq, wb_stall, bus_err}, 37'd0);
    chk({name, "_we"}, {36'd0, reg_we}, {36'd0, (dst != 0)});
    if (dst != 0) chk({name, "_wdata"}, {5'd0, reg_wdata}, {5'd0, exp_lit});
    step();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] data, input int waits);
    int wq_cnt = 0;
    wb_memwr = 1; wb_waddr = addr; wb_wstrb = strb; wb_wdata = data;
    step(); clear_inputs();
    for (int i = 0; i <= waits; i++) begin
      wq_cnt += int'(dmem_wreq);
      chk("st_addr_strb", {1'b0, dmem_waddr, dmem_wstrb}, {1'b0, addr, strb});
      chk("st_data", {5'd0, dmem_wdata}, {5'd0, data});
      chk("st_no_we", {36'd0, reg_we}, 37'd0);
      if (i == waits) dmem_wack = 1;
      step();
    end
    dmem_wack = 0;
    chk("st_wreq_cycles", 37'(wq_cnt), 37'(waits + 1));
    chk("st_done", {34'd0, dmem_wreq, wb_stall, reg_we}, 37'd0);
    step();
  endtask

  task automatic do_misalign(input logic [31:0] addr, input logic [2:0] op);
    exp_err_q.push_back(2'b01);
    issue_load(addr, op, 5'd4);
    chk("mis_pulse", {33'd0, misalign_err, dmem_rreq, wb_stall, reg_we}, {33'd0, 4'b1000});
    step();
    chk("mis_clear", {34'd0, misalign_err, dmem_rreq, reg_we}, 37'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, {29'd0, wb_stall, dmem_rreq, dmem_wreq, reg_we, misalign_err, bus_err, state_dbg},
        37'd0);
    chk({name, "_addr"}, {5'd0, dmem_raddr | dmem_waddr | dmem_wdata | reg_wdata},  37'd0);
    chk({name, "_misc"}, {28'd0, dmem_wstrb, reg_waddr}, 37'd0);
  endtask

  initial begin
    clear_inputs();
    dmem_rvalid = 0; dmem_rdata = '0; dmem_wack = 0;
    reset = 1;
    repeat (2) step();
    check_all_zero("reset");
    reset = 0;
    step();

    // ALU writes, including the x0 suppression.
    do_alu(5'd5, 32'h1234_5678);
    do_alu(5'd0, 32'hFFFF_0000);

    // Byte loads, zero-wait memory.
    do_load("lb",  32'h1003, 3'd0, 5'd6, 32'h80FF_0000, 0, 32'hFFFF_FF80);
    do_load("lbu", 32'h1003, 3'd4, 5'd6, 32'h80FF_0000, 0, 32'h0000_0080);
    // Halfword loads; the 3-wait one answers in the last allowed cycle.
    do_load("lh",  32'h2002, 3'd1, 5'd7, 32'h8001_1234, 3, 32'hFFFF_8001);
    do_load("lhu", 32'h2000, 3'd5, 5'd8, 32'h8001_9234, 1, 32'h0000_9234);
    // Word load, and funct3=7 treated as a word load.
    do_load("lw",  32'h3000, 3'd2, 5'd9, 32'h1357_2468, 2, 32'h1357_2468);
    do_load("lw7", 32'h3004, 3'd7, 5'd10, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
    // Load to x0 performs the access but writes nothing.
    do_load("lb_x0", 32'h1001, 3'd0, 5'd0, 32'h0000_7F00, 0, 32'h0000_007F);

    // Misaligned loads.
    do_misalign(32'h2001, 3'd2);
    do_misalign(32'h2003, 3'd5);

    // Store with two wait cycles.
    do_store(32'h40, 4'hF, 32'hDEAD_BEEF, 2);

    // Load timeout: no response for 4 RD cycles.
    begin
      int rq_cnt = 0;
      exp_err_q.push_back(2'b10);
      issue_load(32'h5000, 3'd2, 5'd11);
      for (int i = 0; i < 4; i++) begin
        rq_cnt += int'(dmem_rreq);
        step();
      end
      chk("to_rreq_cycles", 37'(rq_cnt), 37'd4);
      chk("to_abort", {33'd0, bus_err, dmem_rreq, wb_stall, reg_we}, {33'd0, 4'b1000});
      dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA; dmem_wack = 1;
      step();
      dmem_rvalid = 0; dmem_rdata = '0; dmem_wack = 0;
      chk("stray_ignored", {33'd0, bus_err, reg_we, wb_stall, dmem_rreq}, 37'd0);
      step();
    end

    // Reset while a store waits for its acknowledge.
    wb_memwr = 1; wb_waddr = 32'h80; wb_wstrb = 4'h3; wb_wdata = 32'h0000_BEEF;
    step(); clear_inputs();
    step();
    chk("rst_pre_wreq", {35'd0, dmem_wreq, wb_stall}, {35'd0, 2'b11});
    #2 reset = 1;
    #1 check_all_zero("rst_mid");
    step();
    reset = 0;
    step();
    do_alu(5'd3, 32'hA5A5_A5A5);

    repeat (2) step();
    chk("exp_q_drained", 37'(exp_q.size()), 37'd0);
    chk("err_q_drained", 37'(exp_err_q.size()), 37'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
